// File: rtl/output_port_scheduler.sv
// Output-port wormhole scheduler for one NoC router output.
// Round-robin arbitration among the input buffers, a lock held from head flit
// to tail flit, and a downstream credit counter that gates every flit sent.
module output_port_scheduler #(
    parameter int NUM_INPUTS        = 5,
    parameter int FLIT_BUFFER_DEPTH = 2,
    parameter int CREDIT_WIDTH      = $clog2(FLIT_BUFFER_DEPTH + 1),
    parameter int IDX_WIDTH         = $clog2(NUM_INPUTS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_INPUTS-1:0]   req,
    input  logic [NUM_INPUTS-1:0]   req_is_tail,
    input  logic [NUM_INPUTS-1:0]   disable_turns,
    input  logic                    credit_in,
    output logic [NUM_INPUTS-1:0]   grant,
    output logic                    send_out,
    output logic                    locked,
    output logic [IDX_WIDTH-1:0]    owner,
    output logic [CREDIT_WIDTH-1:0] credits,
    output logic                    credit_overflow
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam logic [CREDIT_WIDTH-1:0] MAX_CREDITS = CREDIT_WIDTH'(FLIT_BUFFER_DEPTH);
    localparam logic [IDX_WIDTH-1:0]    LAST_IDX    = IDX_WIDTH'(NUM_INPUTS - 1);

    state_t                  state_q, state_d;
    logic [IDX_WIDTH-1:0]    owner_q, owner_d;
    logic [IDX_WIDTH-1:0]    rr_ptr_q, rr_ptr_d;
    logic [CREDIT_WIDTH-1:0] credits_q, credits_d;
    logic                    overflow_q, overflow_d;

    logic [NUM_INPUTS-1:0]   elig;
    logic [NUM_INPUTS-1:0]   grant_int;
    logic                    found;
    logic [IDX_WIDTH-1:0]    winner;
    logic [IDX_WIDTH-1:0]    cand;
    logic                    credit_ok;
    logic                    send;

    // Modulo-NUM_INPUTS increment of an input index.
    function automatic logic [IDX_WIDTH-1:0] next_idx(input logic [IDX_WIDTH-1:0] p);
        next_idx = (p == LAST_IDX) ? '0 : p + IDX_WIDTH'(1);
    endfunction

    // A request masked by the turn table can never win this output.
    generate
        for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_elig
            assign elig[gi] = req[gi] & ~disable_turns[gi];
        end
    endgenerate

    // Round-robin search: first eligible input starting at rr_ptr, wrapping.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = rr_ptr_q;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            if (!found && elig[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
            cand = next_idx(cand);
        end
    end

    // Lock FSM: grant selection, lock/unlock and pointer advance on tail.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rr_ptr_d  = rr_ptr_q;
        grant_int = '0;
        credit_ok = (credits_q != '0);
        case (state_q)
            IDLE: begin
                if (rst_n && credit_ok && found) begin
                    grant_int[winner] = 1'b1;
                    if (req_is_tail[winner]) begin
                        rr_ptr_d = next_idx(winner);
                    end else begin
                        state_d = LOCKED;
                        owner_d = winner;
                    end
                end
            end
            LOCKED: begin
                // Only the owner may move; anything else waits for the tail.
                if (rst_n && credit_ok && elig[owner_q]) begin
                    grant_int[owner_q] = 1'b1;
                    if (req_is_tail[owner_q]) begin
                        state_d  = IDLE;
                        rr_ptr_d = next_idx(owner_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign send = |grant_int;

    // Credit bookkeeping; a returned credit only becomes spendable next cycle.
    always_comb begin
        credits_d  = credits_q;
        overflow_d = overflow_q;
        case ({send, credit_in})
            2'b10: credits_d = credits_q - CREDIT_WIDTH'(1);
            2'b01: begin
                if (credits_q == MAX_CREDITS) begin
                    overflow_d = 1'b1;
                end else begin
                    credits_d = credits_q + CREDIT_WIDTH'(1);
                end
            end
            default: credits_d = credits_q;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            credits_q  <= MAX_CREDITS;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            credits_q  <= credits_d;
            overflow_q <= overflow_d;
        end
    end

    assign grant           = grant_int;
    assign send_out        = send;
    assign locked          = (state_q == LOCKED);
    assign owner           = owner_q;
    assign credits         = credits_q;
    assign credit_overflow = overflow_q;

endmodule

// File: tb/tb_output_port_scheduler.sv
// Directed testbench for output_port_scheduler (NUM_INPUTS=5, depth 2).
// Inputs change just after the falling edge; outputs are sampled 1 ns later,
// so registered outputs reflect every rising edge seen so far.
module tb_output_port_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] req;
    logic [4:0] req_is_tail;
    logic [4:0] disable_turns;
    logic       credit_in;
    logic [4:0] grant;
    logic       send_out;
    logic       locked;
    logic [2:0] owner;
    logic [1:0] credits;
    logic       credit_overflow;

    int total = 0;
    int bad   = 0;

    output_port_scheduler dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req             (req),
        .req_is_tail     (req_is_tail),
        .disable_turns   (disable_turns),
        .credit_in       (credit_in),
        .grant           (grant),
        .send_out        (send_out),
        .locked          (locked),
        .owner           (owner),
        .credits         (credits),
        .credit_overflow (credit_overflow)
    );

    always #5 clk = ~clk;

    // Apply one cycle of inputs and settle before sampling.
    task automatic drive(input logic r_n, input logic [4:0] r, input logic [4:0] t,
                         input logic [4:0] d, input logic c);
        @(negedge clk);
        rst_n         = r_n;
        req           = r;
        req_is_tail   = t;
        disable_turns = d;
        credit_in     = c;
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, 5'b0, 5'b0, 5'b0, 1'b0);
        drive(1'b0, 5'b0, 5'b0, 5'b0, 1'b0);
    endtask

    task automatic test_reset();
        drive(1'b0, 5'b11111, 5'b11111, 5'b0, 1'b0);
        drive(1'b0, 5'b11111, 5'b11111, 5'b0, 1'b0);
        total++; if (grant !== 5'b0) begin bad++; $display("FAIL reset_grant got=%b exp=%b", grant, 5'b0); end
        total++; if (send_out !== 1'b0) begin bad++; $display("FAIL reset_send got=%b exp=0", send_out); end
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL reset_locked got=%b exp=0", locked); end
        total++; if (credits !== 2'd2) begin bad++; $display("FAIL reset_credits got=%0d exp=2", credits); end
        total++; if (credit_overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", credit_overflow); end
        total++; if (owner !== 3'd0) begin bad++; $display("FAIL reset_owner got=%0d exp=0", owner); end
        $display("test_reset: grant=%b credits=%0d locked=%b", grant, credits, locked);
    endtask

    task automatic test_round_robin();
        logic [4:0] exp_g [4] = '{5'b00010, 5'b00100, 5'b00010, 5'b00100};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 5'b00110, 5'b11111, 5'b0, 1'b1);
            total++; if (grant !== exp_g[i]) begin bad++; $display("FAIL rr_grant%0d got=%b exp=%b", i, grant, exp_g[i]); end
            total++; if (credits !== 2'd2) begin bad++; $display("FAIL rr_credits%0d got=%0d exp=2", i, credits); end
            $display("test_round_robin: cycle %0d grant=%b credits=%0d", i, grant, credits);
        end
        drive(1'b1, 5'b0, 5'b0, 5'b0, 1'b0);
        total++; if (credits !== 2'd2) begin bad++; $display("FAIL rr_credits_end got=%0d exp=2", credits); end
        total++; if (credit_overflow !== 1'b0) begin bad++; $display("FAIL rr_ovf got=%b exp=0", credit_overflow); end
    endtask

    task automatic test_wormhole();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 5'b01001, (i == 3) ? 5'b01001 : 5'b01000, 5'b0, 1'b1);
            total++; if (grant !== 5'b00001) begin bad++; $display("FAIL worm_grant%0d got=%b exp=%b", i, grant, 5'b00001); end
            total++; if (locked !== (i != 0)) begin bad++; $display("FAIL worm_locked%0d got=%b exp=%b", i, locked, (i != 0)); end
            if (i != 0) begin
                total++; if (owner !== 3'd0) begin bad++; $display("FAIL worm_owner%0d got=%0d exp=0", i, owner); end
            end
            $display("test_wormhole: flit %0d grant=%b locked=%b", i, grant, locked);
        end
        // rr_ptr is now 1: input3 beats input0 on the following cycle.
        drive(1'b1, 5'b01001, 5'b01001, 5'b0, 1'b1);
        total++; if (grant !== 5'b01000) begin bad++; $display("FAIL worm_next got=%b exp=%b", grant, 5'b01000); end
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL worm_unlock got=%b exp=0", locked); end
        $display("test_wormhole: after tail grant=%b", grant);
    endtask

    task automatic test_credit_block();
        logic [4:0] exp_g [6] = '{5'b00100, 5'b00100, 5'b0, 5'b0, 5'b00100, 5'b0};
        logic [1:0] exp_c [6] = '{2'd2, 2'd1, 2'd0, 2'd0, 2'd1, 2'd0};
        logic       cin   [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 5'b00100, 5'b0, 5'b0, cin[i]);
            total++; if (grant !== exp_g[i]) begin bad++; $display("FAIL credit_grant%0d got=%b exp=%b", i, grant, exp_g[i]); end
            total++; if (credits !== exp_c[i]) begin bad++; $display("FAIL credit_cnt%0d got=%0d exp=%0d", i, credits, exp_c[i]); end
            $display("test_credit_block: cycle %0d credit_in=%b grant=%b credits=%0d", i, cin[i], grant, credits);
        end
    endtask

    task automatic test_disable_turns();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'b00001, 5'b11111, 5'b00001, 1'b0);
            total++; if (grant !== 5'b0) begin bad++; $display("FAIL dis_masked%0d got=%b exp=%b", i, grant, 5'b0); end
        end
        total++; if (credits !== 2'd2) begin bad++; $display("FAIL dis_credits got=%0d exp=2", credits); end
        drive(1'b1, 5'b10001, 5'b11111, 5'b00001, 1'b0);
        total++; if (grant !== 5'b10000) begin bad++; $display("FAIL dis_other got=%b exp=%b", grant, 5'b10000); end
        $display("test_disable_turns: grant=%b", grant);
    endtask

    task automatic test_credit_overflow();
        do_reset();
        drive(1'b1, 5'b00010, 5'b0, 5'b0, 1'b0);
        total++; if (grant !== 5'b00010) begin bad++; $display("FAIL ovf_head got=%b exp=%b", grant, 5'b00010); end
        drive(1'b1, 5'b00010, 5'b0, 5'b0, 1'b1);
        total++; if (credits !== 2'd1) begin bad++; $display("FAIL ovf_c1 got=%0d exp=1", credits); end
        total++; if (grant !== 5'b00010) begin bad++; $display("FAIL ovf_body got=%b exp=%b", grant, 5'b00010); end
        drive(1'b1, 5'b0, 5'b0, 5'b0, 1'b1);
        total++; if (credits !== 2'd1) begin bad++; $display("FAIL ovf_same got=%0d exp=1", credits); end
        drive(1'b1, 5'b0, 5'b0, 5'b0, 1'b1);
        total++; if (credits !== 2'd2) begin bad++; $display("FAIL ovf_c2 got=%0d exp=2", credits); end
        total++; if (credit_overflow !== 1'b0) begin bad++; $display("FAIL ovf_early got=%b exp=0", credit_overflow); end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'b0, 5'b0, 5'b0, 1'b0);
            total++; if (credit_overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky%0d got=%b exp=1", i, credit_overflow); end
            total++; if (credits !== 2'd2) begin bad++; $display("FAIL ovf_sat%0d got=%0d exp=2", i, credits); end
        end
        $display("test_credit_overflow: credits=%0d overflow=%b", credits, credit_overflow);
        do_reset();
        drive(1'b1, 5'b0, 5'b0, 5'b0, 1'b0);
        total++; if (credit_overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b exp=0", credit_overflow); end
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        drive(1'b1, 5'b01000, 5'b0, 5'b0, 1'b0);
        total++; if (grant !== 5'b01000) begin bad++; $display("FAIL midrst_head got=%b exp=%b", grant, 5'b01000); end
        drive(1'b1, 5'b01000, 5'b0, 5'b0, 1'b0);
        drive(1'b1, 5'b01000, 5'b0, 5'b0, 1'b0);
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL midrst_locked got=%b exp=1", locked); end
        total++; if (owner !== 3'd3) begin bad++; $display("FAIL midrst_owner got=%0d exp=3", owner); end
        total++; if (credits !== 2'd0) begin bad++; $display("FAIL midrst_credits got=%0d exp=0", credits); end
        drive(1'b0, 5'b01000, 5'b0, 5'b0, 1'b1);
        total++; if (grant !== 5'b0) begin bad++; $display("FAIL midrst_grant got=%b exp=%b", grant, 5'b0); end
        drive(1'b1, 5'b11111, 5'b11111, 5'b0, 1'b0);
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL midrst_unlock got=%b exp=0", locked); end
        total++; if (credits !== 2'd2) begin bad++; $display("FAIL midrst_restore got=%0d exp=2", credits); end
        total++; if (grant !== 5'b00001) begin bad++; $display("FAIL midrst_restart got=%b exp=%b", grant, 5'b00001); end
        $display("test_reset_mid_packet: grant=%b credits=%0d locked=%b", grant, credits, locked);
    endtask

    initial begin
        rst_n         = 1'b0;
        req           = '0;
        req_is_tail   = '0;
        disable_turns = '0;
        credit_in     = 1'b0;
        test_reset();
        test_round_robin();
        test_wormhole();
        test_credit_block();
        test_disable_turns();
        test_credit_overflow();
        test_reset_mid_packet();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
